posit_round_pipe: RTL and testbench

Pipelined, handshaked posit encoder/rounder for the posit FPU, parametrised in N and ES. Accepts an unpacked result (sign, regime value k, exponent, MSB-aligned fraction, zero/NaR flags) from the add/mul/div datapaths. Produces the packed, rounded N-bit posit three cycles later. Supports round-to-nearest-even and round-toward-zero per operation, applies posit saturation, and holds data under downstream backpressure.

---
 rtl/posit_round_pipe.sv | 179 +++++++++++++++++
 tb/tb_posit_round_pipe.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_round_pipe.sv
// posit_round_pipe: three-stage posit encoder/rounder (RNE or RTZ per beat) with a valid/ready handshake.
// Define POSIT_RND_INEXACT_EN to add the registered out_inexact flag.
module posit_round_pipe #(
    parameter int N  = 32,
    parameter int ES = 2,
    localparam int RS = $clog2(N),
    // A zero-width exponent port is not legal, so ES=0 keeps one ignored bit
    localparam int EW = (ES > 0) ? ES : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sign,
    input  logic signed [RS+1:0] in_k,
    input  logic [EW-1:0]        in_exp,
    input  logic [2*N-1:0]       in_frac,
    input  logic                 in_zero,
    input  logic                 in_nar,
    input  logic                 in_rtz,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out_posit
`ifdef POSIT_RND_INEXACT_EN
    ,
    output logic                 out_inexact
`endif
);

    localparam int TL = 1 + ES + 2 * N;
    localparam int BW = N + TL;
    localparam logic signed [RS+1:0] K_MAX = (RS + 2)'(N - 2);
    localparam logic signed [RS+1:0] K_MIN = (RS + 2)'(-(N - 1));
    localparam logic signed [RS+1:0] K_ONE = (RS + 2)'(1);
    localparam logic [RS+1:0]        N_W   = (RS + 2)'(N);
    localparam logic [N-2:0]         MAXMAG = '1;
    localparam logic [N-2:0]         MINMAG = (N - 1)'(1);

    logic en;
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    logic                 s1_valid, s1_sign, s1_zero, s1_nar, s1_rtz;
    logic signed [RS+1:0] s1_k;
    logic [EW-1:0]        s1_exp;
    logic [2*N-1:0]       s1_frac;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_zero  <= 1'b0;
            s1_nar   <= 1'b0;
            s1_rtz   <= 1'b0;
            s1_k     <= '0;
            s1_exp   <= '0;
            s1_frac  <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_sign  <= in_sign;
            s1_zero  <= in_zero;
            s1_nar   <= in_nar;
            s1_rtz   <= in_rtz;
            s1_k     <= in_k;
            s1_exp   <= in_exp;
            s1_frac  <= in_frac;
        end
    end

    // Regime is built by shifting the terminated tail under a run of fill bits
    logic          k_neg, c_max, c_min;
    logic [RS+1:0] run_len, shamt;
    logic [TL-1:0] tail;
    logic [BW-1:0] body;
    logic [N-2:0]  p_next;
    logic          g_next, s_next;

    assign k_neg   = s1_k[RS+1];
    assign c_max   = (s1_k >= K_MAX);
    assign c_min   = (s1_k <= K_MIN);
    assign run_len = k_neg ? -s1_k : (s1_k + K_ONE);
    assign shamt   = N_W - run_len;

    if (ES > 0) begin : g_exp
        assign tail = {k_neg, s1_exp, s1_frac};
    end else begin : g_noexp
        assign tail = {k_neg, s1_frac};
    end

    assign body   = {{N{~k_neg}}, tail} << shamt;
    assign p_next = body[BW-1 -: N-1];
    assign g_next = body[BW-N];
    assign s_next = |body[BW-N-1:0];

    logic         s2_valid, s2_sign, s2_zero, s2_nar, s2_rtz;
    logic         s2_g, s2_s, s2_cmax, s2_cmin;
    logic [N-2:0] s2_p;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_zero  <= 1'b0;
            s2_nar   <= 1'b0;
            s2_rtz   <= 1'b0;
            s2_g     <= 1'b0;
            s2_s     <= 1'b0;
            s2_cmax  <= 1'b0;
            s2_cmin  <= 1'b0;
            s2_p     <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_zero  <= s1_zero;
            s2_nar   <= s1_nar;
            s2_rtz   <= s1_rtz;
            s2_g     <= g_next;
            s2_s     <= s_next;
            s2_cmax  <= c_max;
            s2_cmin  <= c_min;
            s2_p     <= p_next;
        end
    end

    logic         inc;
    logic [N-1:0] sum, word, posit_next;
    logic [N-2:0] mag;

    // A nonzero value must never round into zero or NaR, hence the two fix-ups
    always_comb begin
        inc = ~s2_rtz & s2_g & (s2_s | s2_p[0]);
        sum = {1'b0, s2_p} + {{(N - 1){1'b0}}, inc};
        mag = sum[N-2:0];
        if (s2_cmax) begin
            mag = MAXMAG;
        end else if (s2_cmin) begin
            mag = MINMAG;
        end else if (sum[N-1]) begin
            mag = MAXMAG;
        end else if (sum[N-2:0] == '0) begin
            mag = MINMAG;
        end
        word = {1'b0, mag};
        if (s2_sign) begin
            word = -word;
        end
        posit_next = word;
        if (s2_nar) begin
            posit_next = {1'b1, {(N - 1){1'b0}}};
        end else if (s2_zero) begin
            posit_next = '0;
        end
    end

`ifdef POSIT_RND_INEXACT_EN
    logic inexact_next;
    assign inexact_next = ~(s2_nar | s2_zero) &
                          (s2_g | s2_s | s2_cmax | s2_cmin | sum[N-1] | (sum[N-2:0] == '0));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_posit   <= '0;
`ifdef POSIT_RND_INEXACT_EN
            out_inexact <= 1'b0;
`endif
        end else if (en) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_posit   <= posit_next;
`ifdef POSIT_RND_INEXACT_EN
                out_inexact <= inexact_next;
`endif
            end
        end
    end

endmodule

// File: tb/tb_posit_round_pipe.sv
// tb_posit_round_pipe: scoreboard bench for posit_round_pipe (N=8/ES=0 directed, N=16/ES=1 random).
// Honors POSIT_RND_INEXACT_EN to also score out_inexact.
module tb_posit_round_pipe;

    typedef struct packed {
        bit              sign;
        bit signed [31:0] k;
        bit [3:0]        exp;
        bit [63:0]       frac;
        bit              zero;
        bit              nar;
        bit              rtz;
    } beat_t;

    typedef struct packed {
        bit [15:0] posit;
        bit        inexact;
    } resp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic              a_in_valid, a_in_ready, a_in_sign, a_in_zero, a_in_nar, a_in_rtz;
    logic signed [4:0] a_in_k;
    logic [0:0]        a_in_exp;
    logic [15:0]       a_in_frac;
    logic              a_out_valid, a_out_ready, a_out_inexact;
    logic [7:0]        a_out_posit;

    logic              b_in_valid, b_in_ready, b_in_sign, b_in_zero, b_in_nar, b_in_rtz;
    logic signed [5:0] b_in_k;
    logic [0:0]        b_in_exp;
    logic [31:0]       b_in_frac;
    logic              b_out_valid, b_out_ready, b_out_inexact;
    logic [15:0]       b_out_posit;

    resp_t q8[$];
    resp_t q16[$];
    resp_t e8, e16;

    always #5 clk = ~clk;

    posit_round_pipe #(.N(8), .ES(0)) dut8 (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_sign(a_in_sign), .in_k(a_in_k), .in_exp(a_in_exp), .in_frac(a_in_frac),
        .in_zero(a_in_zero), .in_nar(a_in_nar), .in_rtz(a_in_rtz),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_posit(a_out_posit)
`ifdef POSIT_RND_INEXACT_EN
        , .out_inexact(a_out_inexact)
`endif
    );

    posit_round_pipe #(.N(16), .ES(1)) dut16 (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_sign(b_in_sign), .in_k(b_in_k), .in_exp(b_in_exp), .in_frac(b_in_frac),
        .in_zero(b_in_zero), .in_nar(b_in_nar), .in_rtz(b_in_rtz),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_posit(b_out_posit)
`ifdef POSIT_RND_INEXACT_EN
        , .out_inexact(b_out_inexact)
`endif
    );

`ifndef POSIT_RND_INEXACT_EN
    assign a_out_inexact = 1'b0;
    assign b_out_inexact = 1'b0;
`endif

    // Reference model: writes the body string bit by bit and rounds with integer arithmetic
    function automatic resp_t model(input int n, input int es, input beat_t b);
        resp_t           r;
        bit              body[$];
        longint unsigned p, maxmag;
        bit              g, s;
        r = '0;
        if (b.nar) begin
            r.posit = 16'(64'd1 << (n - 1));
            return r;
        end
        if (b.zero) return r;
        maxmag = (64'd1 << (n - 1)) - 1;
        if (b.k >= n - 2) begin
            p = maxmag;
            r.inexact = 1'b1;
        end else if (b.k <= -(n - 1)) begin
            p = 1;
            r.inexact = 1'b1;
        end else begin
            if (b.k >= 0) begin
                repeat (b.k + 1) body.push_back(1'b1);
                body.push_back(1'b0);
            end else begin
                repeat (-b.k) body.push_back(1'b0);
                body.push_back(1'b1);
            end
            for (int i = es - 1; i >= 0; i--) body.push_back(b.exp[i]);
            for (int i = 2 * n - 1; i >= 0; i--) body.push_back(b.frac[i]);
            p = 0;
            for (int i = 0; i < n - 1; i++) p = p * 2 + longint'(body[i]);
            g = body[n - 1];
            s = 1'b0;
            for (int i = n; i < body.size(); i++) s |= body[i];
            r.inexact = g | s;
            if (!b.rtz && g && (s || p[0])) p++;
            if (p > maxmag) p = maxmag;
            if (p == 0) p = 1;
        end
        if (b.sign) p = ((64'd1 << n) - p) & ((64'd1 << n) - 1);
        r.posit = 16'(p);
        return r;
    endfunction

    function automatic beat_t mk(input bit sign, input int k, input bit [63:0] frac,
                                 input bit zero, input bit nar, input bit rtz);
        beat_t b;
        b = '0;
        b.sign = sign;
        b.k    = k;
        b.frac = frac;
        b.zero = zero;
        b.nar  = nar;
        b.rtz  = rtz;
        return b;
    endfunction

    function automatic beat_t randBeat();
        beat_t b;
        b = '0;
        b.sign = 1'($urandom_range(0, 1));
        b.k    = int'($urandom_range(0, 40)) - 20;
        b.exp  = 4'($urandom_range(0, 15));
        b.frac = {32'd0, $urandom() & (32'hFFFF_FFFF << $urandom_range(0, 31))};
        b.nar  = ($urandom_range(0, 15) == 0);
        b.zero = ($urandom_range(0, 15) == 0);
        b.rtz  = 1'($urandom_range(0, 1));
        return b;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic driveBeat(input bit sel, input beat_t b);
        if (sel) begin
            b_in_sign = b.sign; b_in_k = 6'(b.k); b_in_exp = b.exp[0];
            b_in_frac = b.frac[31:0]; b_in_zero = b.zero; b_in_nar = b.nar; b_in_rtz = b.rtz;
        end else begin
            a_in_sign = b.sign; a_in_k = 5'(b.k); a_in_exp = b.exp[0];
            a_in_frac = b.frac[15:0]; a_in_zero = b.zero; a_in_nar = b.nar; a_in_rtz = b.rtz;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat was taken
    task automatic applyStimulus(input bit sel, input beat_t b, input resp_t e);
        int waited = 0;
        driveBeat(sel, b);
        if (sel) b_in_valid = 1'b1; else a_in_valid = 1'b1;
        @(negedge clk);
        while (!(sel ? b_in_ready : a_in_ready) && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!(sel ? b_in_ready : a_in_ready)) begin
            checkOutput(sel ? "n16_accept_timeout" : "n8_accept_timeout", 64'd0, 64'd1);
        end else if (sel) begin
            q16.push_back(e);
        end else begin
            q8.push_back(e);
        end
        @(posedge clk);
        #1;
        if (sel) b_in_valid = 1'b0; else a_in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && a_out_valid && a_out_ready) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL n8_unexpected: got 0x%0h, expected no output", a_out_posit);
            end else begin
                e8 = q8.pop_front();
                checkOutput("n8_posit", 64'(a_out_posit), 64'(e8.posit[7:0]));
`ifdef POSIT_RND_INEXACT_EN
                checkOutput("n8_inexact", 64'(a_out_inexact), 64'(e8.inexact));
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b_out_valid && b_out_ready) begin
            if (q16.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL n16_unexpected: got 0x%0h, expected no output", b_out_posit);
            end else begin
                e16 = q16.pop_front();
                checkOutput("n16_posit", 64'(b_out_posit), 64'(e16.posit));
`ifdef POSIT_RND_INEXACT_EN
                checkOutput("n16_inexact", 64'(b_out_inexact), 64'(e16.inexact));
`endif
            end
        end
    end

    // A stalled output must hold both valid and data
    logic        stall_prev = 1'b0;
    logic [15:0] posit_prev = '0;
    always @(negedge clk) begin
        if (rst) begin
            stall_prev <= 1'b0;
        end else begin
            if (stall_prev) begin
                checkOutput("n16_hold_valid", 64'(b_out_valid), 64'd1);
                checkOutput("n16_hold_posit", 64'(b_out_posit), 64'(posit_prev));
            end
            stall_prev <= b_out_valid & ~b_out_ready;
            posit_prev <= b_out_posit;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        beat_t b;
        beat_t dir_b[$];
        resp_t dir_e[$];
        beat_t bp[4];

        rst = 1'b1;
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        driveBeat(1'b0, '0);
        driveBeat(1'b1, '0);
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("n8_reset_valid", 64'(a_out_valid), 64'd0);
        checkOutput("n8_reset_posit", 64'(a_out_posit), 64'd0);
        checkOutput("n16_reset_valid", 64'(b_out_valid), 64'd0);
        checkOutput("n16_reset_posit", 64'(b_out_posit), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("n8_ready_after_reset", 64'(a_in_ready), 64'd1);
        checkOutput("n16_ready_after_reset", 64'(b_in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Directed N=8, ES=0 values with hand-derived expectations
        dir_b.push_back(mk(0,   0, 64'h0000, 0, 0, 0)); dir_e.push_back('{16'h40, 1'b0});
        dir_b.push_back(mk(1,   0, 64'h0000, 0, 0, 0)); dir_e.push_back('{16'hC0, 1'b0});
        dir_b.push_back(mk(0,   0, 64'h8000, 0, 0, 0)); dir_e.push_back('{16'h50, 1'b0});
        dir_b.push_back(mk(0,   0, 64'h0C00, 0, 0, 0)); dir_e.push_back('{16'h42, 1'b1});
        dir_b.push_back(mk(0,   0, 64'h0C00, 0, 0, 1)); dir_e.push_back('{16'h41, 1'b1});
        dir_b.push_back(mk(0,   0, 64'h0400, 0, 0, 0)); dir_e.push_back('{16'h40, 1'b1});
        dir_b.push_back(mk(0,   0, 64'h0400, 0, 0, 1)); dir_e.push_back('{16'h40, 1'b1});
        dir_b.push_back(mk(0,  10, 64'h0000, 0, 0, 0)); dir_e.push_back('{16'h7F, 1'b1});
        dir_b.push_back(mk(0, -10, 64'h0000, 0, 0, 0)); dir_e.push_back('{16'h01, 1'b1});
        dir_b.push_back(mk(1, -10, 64'h0000, 0, 0, 0)); dir_e.push_back('{16'hFF, 1'b1});
        dir_b.push_back(mk(1,   3, 64'hABCD, 0, 1, 0)); dir_e.push_back('{16'h80, 1'b0});
        dir_b.push_back(mk(1,   3, 64'hABCD, 1, 0, 0)); dir_e.push_back('{16'h00, 1'b0});
        dir_b.push_back(mk(0,   1, 64'h1234, 1, 1, 0)); dir_e.push_back('{16'h80, 1'b0});
        foreach (dir_b[i]) applyStimulus(1'b0, dir_b[i], dir_e[i]);
        for (int i = 0; i < 20 && q8.size() != 0; i++) @(posedge clk);
        #1;
        checkOutput("n8_drain", 64'(q8.size()), 64'd0);

        // Backpressure: three beats fill the pipe, the fourth is refused until out_ready rises
        for (int i = 0; i < 4; i++) bp[i] = randBeat();
        @(posedge clk);
        #1;
        b_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, bp[i], model(16, 1, bp[i]));
        driveBeat(1'b1, bp[3]);
        b_in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("n16_bp_ready_low", 64'(b_in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        b_out_ready = 1'b1;
        applyStimulus(1'b1, bp[3], model(16, 1, bp[3]));
        for (int i = 0; i < 20 && q16.size() != 0; i++) @(posedge clk);
        #1;
        checkOutput("n16_bp_drain", 64'(q16.size()), 64'd0);

        // Reset with two beats in flight, one of them already presented
        @(posedge clk);
        #1;
        b_out_ready = 1'b0;
        b = mk(0, 2, 64'h1234_5678, 0, 0, 0);
        applyStimulus(1'b1, b, model(16, 1, b));
        b = mk(1, -3, 64'h8765_4321, 0, 0, 0);
        applyStimulus(1'b1, b, model(16, 1, b));
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("n16_rst_valid", 64'(b_out_valid), 64'd0);
        checkOutput("n16_rst_posit", 64'(b_out_posit), 64'd0);
        q16.delete();
        b_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("n16_rst_ready", 64'(b_in_ready), 64'd1);
        repeat (5) begin
            @(negedge clk);
            checkOutput("n16_no_stale", 64'(b_out_valid), 64'd0);
        end
        @(posedge clk);
        #1;

        // Random stream with random valid and ready
        for (int i = 0; i < 800; i++) begin
            b = randBeat();
            driveBeat(1'b1, b);
            b_in_valid  = ($urandom_range(0, 3) != 0);
            b_out_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            if (b_in_valid && b_in_ready) q16.push_back(model(16, 1, b));
            @(posedge clk);
            #1;
        end
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        for (int i = 0; i < 20 && q16.size() != 0; i++) @(posedge clk);
        #1;
        checkOutput("n16_rand_drain", 64'(q16.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
